touch_region_grid: RTL and testbench
====================================

Name: touch_region_grid

Overview:
- Parametrised touch-driven colour grid for the LTM panel. The screen is split into COLS x ROWS rectangular regions, and each region holds a 3-bit colour index.
- Each distinct touch advances the colour index of the touched region by one. A held or bouncing touch never advances it more than once.
- Sits between Touch_Panel_Controller (coordinate source) and LCD_Data_Controller (pixel sink). Returns RGB for the pixel coordinate the LCD controller requests.

Parameters:
- COLS, 4, region columns; power of two, 1..8
- ROWS, 2, region rows; power of two, 1..8; COLS*ROWS <= 16
- SCREEN_W, 800, visible pixels per line
- SCREEN_H, 480, visible lines
- RELEASE_CYCLES, 16'd50000, consecutive Touch_En-low cycles required to re-arm (1 ms at 50 MHz)

Ports:
- Clock  in  1  system clock, 50 MHz
- Resetn  in  1  asynchronous active-low reset
- Touch_En  in  1  pen-down level from touch controller
- Coord_En  in  1  one-cycle pulse: X_Coord/Y_Coord valid
- X_Coord  in  12  touch X, 0..4095, maps linearly to 0..SCREEN_W
- Y_Coord  in  12  touch Y, 0..4095, maps linearly to 0..SCREEN_H
- Clear  in  1  synchronous pulse: restore initial colours
- Coord_X  in  10  pixel X requested by LCD controller
- Coord_Y  in  10  pixel Y requested by LCD controller
- Red  out  8  pixel red
- Green  out  8  pixel green
- Blue  out  8  pixel blue
- Region  out  4  index of last accepted touch region
- Update  out  1  one-cycle pulse when a region colour advances
- Touch_Count  out  8  accepted touches, wraps 255->0

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - colour[r] = r mod 8
  - Red/Green/Blue = 0
  - Region = 0
  - Update = 0
  - Touch_Count = 0
  - FSM = S_IDLE
  - release counter = 0
- Region index = row*COLS + col.
  - Touch col = X_Coord[11 -: log2(COLS)]; touch row = Y_Coord[11 -: log2(ROWS)]. A parameter of 1 gives index 0.
- Pixel region boundaries are elaboration-time constants: bx[k] = k*SCREEN_W/COLS and by[k] = k*SCREEN_H/ROWS, with floor division.
  - Pixel col = largest k such that Coord_X >= bx[k].
  - Coord_X >= SCREEN_W clamps to col COLS-1; Coord_Y behaves the same way.
- Colour mapping for index c: Red = {8{c[0]}}, Blue = {8{c[1]}}, Green = {8{c[2]}}.
- Pixel path latency: exactly 1 cycle, with RGB registered from Coord_X/Coord_Y. It is independent of the FSM.
  - A colour update in cycle n is visible on pixel outputs from cycle n+2.
- FSM:
  - S_IDLE: if Coord_En & Touch_En, latch the computed region into Region and go to S_UPDATE. Coord_En with Touch_En=0 is ignored.
  - S_UPDATE (1 cycle): colour[Region] <= colour[Region]+1 (mod 8), Touch_Count++, Update=1. Clear the release counter and go to S_HOLD.
  - S_HOLD: Coord_En is ignored.
    - Touch_En=1 clears the release counter.
    - Touch_En=0 increments it.
    - When the counter reaches RELEASE_CYCLES-1 with Touch_En=0, go to S_IDLE.
- Clear: in the same cycle, restores all colours to their initial values. Touch_Count, Region and the FSM state are unaffected. If Clear coincides with S_UPDATE, Clear wins: the colour is not advanced, but Touch_Count still increments and Update still pulses.
- Unused region slots (index >= COLS*ROWS) never exist; indices are always in range by construction.
- Reset mid-operation: all state returns to reset values immediately, and the next touch is accepted from S_IDLE.

Optional Feature:
- Macro: TOUCH_REGION_GRID_LINES_EN.
- Defined: pixels whose Coord_X or Coord_Y lies within 1 of any interior boundary are drawn white (all 8'hFF). The checks are bx[k] or bx[k]-1 for k=1..COLS-1, and the same for by. The 1-cycle latency is kept.
- Undefined: no grid lines; region colour everywhere.

Test Plan:
- Reset, then sweep Coord_X=0..799, Coord_Y=0 -> region 0 black, region 1 red, region 2 blue, region 3 red+blue. Boundaries switch at X=200/400/600, one cycle after the coordinate.
- Touch_En=1, Coord_En pulse with X=12'hC10, Y=12'h900 -> Region=7, Update pulses once, colour[7] goes 7->0, and pixel (700,300) goes black two cycles later.
- Same touch held 10,000 cycles with Coord_En pulsing every 100 cycles -> Touch_Count increments exactly once.
- Release for 49,999 cycles, press, release 50,000 cycles, touch region 2 -> only the final touch is accepted: colour[2] 2->3, Touch_Count=2.
- Clear asserted in the S_UPDATE cycle of region 5 -> colour[5]=5, all other colours at initial values, Touch_Count incremented.
- With TOUCH_REGION_GRID_LINES_EN defined -> pixels X=199,200 and Y=239,240 white; X=198 region colour.

Source files
------------

// File: rtl/touch_region_grid_if.sv
// touch_region_grid_if: touch coordinate, LCD pixel and status signals of touch_region_grid
interface touch_region_grid_if;
    logic        Touch_En;
    logic        Coord_En;
    logic [11:0] X_Coord;
    logic [11:0] Y_Coord;
    logic        Clear;
    logic [9:0]  Coord_X;
    logic [9:0]  Coord_Y;
    logic [7:0]  Red;
    logic [7:0]  Green;
    logic [7:0]  Blue;
    logic [3:0]  Region;
    logic        Update;
    logic [7:0]  Touch_Count;
    modport master (
        output Touch_En, Coord_En, X_Coord, Y_Coord, Clear, Coord_X, Coord_Y,
        input  Red, Green, Blue, Region, Update, Touch_Count
    );
    modport slave (
        input  Touch_En, Coord_En, X_Coord, Y_Coord, Clear, Coord_X, Coord_Y,
        output Red, Green, Blue, Region, Update, Touch_Count
    );
endinterface

// File: rtl/touch_region_grid.sv
// touch_region_grid: touch-driven COLS x ROWS colour grid; TOUCH_REGION_GRID_LINES_EN draws white region borders
module touch_region_grid #(
    parameter int          COLS           = 4,
    parameter int          ROWS           = 2,
    parameter int          SCREEN_W       = 800,
    parameter int          SCREEN_H       = 480,
    parameter logic [15:0] RELEASE_CYCLES = 16'd50000
) (
    input logic Clock,
    input logic Resetn,
    touch_region_grid_if.slave bus
);
    localparam int CB   = $clog2(COLS);
    localparam int RB   = $clog2(ROWS);
    localparam int NREG = COLS * ROWS;
    localparam int IW   = NREG > 1 ? $clog2(NREG) : 1;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_UPDATE = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;

    logic [1:0]  state;
    logic [3:0]  region_q;
    logic [7:0]  count_q;
    logic [15:0] rel_cnt;
    logic [2:0]  colour [NREG];
    logic [3:0]  touch_col, touch_row, touch_region;
    logic [3:0]  pix_col, pix_row;
    logic [IW-1:0] pix_idx;
    logic [2:0]  pix_c;
    logic        on_line;
    logic [7:0]  red_q, green_q, blue_q;

    function automatic int bx(int k);
        return k * SCREEN_W / COLS;
    endfunction

    function automatic int by(int k);
        return k * SCREEN_H / ROWS;
    endfunction

    // Touch region from the top bits of the touch coordinates; a shift by 12 yields index 0
    assign touch_col    = 4'(bus.X_Coord >> (12 - CB));
    assign touch_row    = 4'(bus.Y_Coord >> (12 - RB));
    assign touch_region = (touch_row << CB) | touch_col;

    // Pixel region: largest boundary not above the coordinate, which also clamps off-screen values
    always_comb begin
        pix_col = '0;
        pix_row = '0;
        for (int k = 1; k < COLS; k++)
            if (int'(bus.Coord_X) >= bx(k)) pix_col = 4'(k);
        for (int k = 1; k < ROWS; k++)
            if (int'(bus.Coord_Y) >= by(k)) pix_row = 4'(k);
    end

    assign pix_idx = IW'((pix_row << CB) | pix_col);
    assign pix_c   = colour[pix_idx];

    // Grid-line detection on both pixels adjacent to each interior boundary
    always_comb begin
        on_line = 1'b0;
`ifdef TOUCH_REGION_GRID_LINES_EN
        for (int k = 1; k < COLS; k++)
            if (int'(bus.Coord_X) == bx(k) || int'(bus.Coord_X) == bx(k) - 1) on_line = 1'b1;
        for (int k = 1; k < ROWS; k++)
            if (int'(bus.Coord_Y) == by(k) || int'(bus.Coord_Y) == by(k) - 1) on_line = 1'b1;
`endif
    end

    // Registered pixel colour, one cycle behind the requested coordinate
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else begin
            red_q   <= on_line ? 8'hFF : {8{pix_c[0]}};
            green_q <= on_line ? 8'hFF : {8{pix_c[2]}};
            blue_q  <= on_line ? 8'hFF : {8{pix_c[1]}};
        end
    end

    // Region colours: Clear restores initial values and overrides an advance in the same cycle
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn || bus.Clear) begin
            for (int r = 0; r < NREG; r++) colour[r] <= 3'(r);
        end else if (state == S_UPDATE) begin
            colour[region_q[IW-1:0]] <= colour[region_q[IW-1:0]] + 3'd1;
        end
    end

    // Touch FSM: accept one touch, then wait for a sustained release before re-arming
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state    <= S_IDLE;
            region_q <= '0;
            count_q  <= '0;
            rel_cnt  <= '0;
        end else if (state == S_IDLE) begin
            if (bus.Coord_En && bus.Touch_En) begin
                region_q <= touch_region;
                state    <= S_UPDATE;
            end
        end else if (state == S_UPDATE) begin
            count_q <= count_q + 8'd1;
            rel_cnt <= '0;
            state   <= S_HOLD;
        end else if (bus.Touch_En) begin
            rel_cnt <= '0;
        end else if (rel_cnt == RELEASE_CYCLES - 16'd1) begin
            rel_cnt <= '0;
            state   <= S_IDLE;
        end else begin
            rel_cnt <= rel_cnt + 16'd1;
        end
    end

    assign bus.Red         = red_q;
    assign bus.Green       = green_q;
    assign bus.Blue        = blue_q;
    assign bus.Region      = region_q;
    assign bus.Update      = state == S_UPDATE;
    assign bus.Touch_Count = count_q;
endmodule

// File: tb/tb_touch_region_grid.sv
// tb_touch_region_grid: directed scoreboard bench for touch_region_grid
module tb_touch_region_grid;
    localparam logic [15:0] REL = 16'd500;
    localparam int          RELI = 500;

    logic Clock = 1'b0;
    logic Resetn = 1'b1;
    int   compared = 0;
    int   mismatched = 0;
    logic [2:0]  mdl [8];
    logic [23:0] exp_q [$];

    always #5 Clock = ~Clock;

    touch_region_grid_if bus();

    touch_region_grid #(
        .COLS(4), .ROWS(2), .SCREEN_W(800), .SCREEN_H(480), .RELEASE_CYCLES(REL)
    ) dut (
        .Clock(Clock),
        .Resetn(Resetn),
        .bus(bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [23:0] exp_rgb(input int x, input int y);
        int col;
        int row;
        logic [2:0] c;
        col = x >= 600 ? 3 : x >= 400 ? 2 : x >= 200 ? 1 : 0;
        row = y >= 240 ? 1 : 0;
        c = mdl[row * 4 + col];
`ifdef TOUCH_REGION_GRID_LINES_EN
        if (x == 199 || x == 200 || x == 399 || x == 400 || x == 599 || x == 600 ||
            y == 239 || y == 240) return 24'hFFFFFF;
`endif
        return {{8{c[0]}}, {8{c[2]}}, {8{c[1]}}};
    endfunction

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic pix(input int x, input int y, input string tag);
        bus.Coord_X = 10'(x);
        bus.Coord_Y = 10'(y);
        exp_q.push_back(exp_rgb(x, y));
        step();
        chk(tag, {8'h0, bus.Red, bus.Green, bus.Blue}, {8'h0, exp_q.pop_front()});
    endtask

    task automatic touch(input logic [11:0] x, input logic [11:0] y);
        bus.Touch_En = 1'b1;
        bus.X_Coord  = x;
        bus.Y_Coord  = y;
        bus.Coord_En = 1'b1;
        step();
        bus.Coord_En = 1'b0;
    endtask

    task automatic release_for(input int n);
        bus.Touch_En = 1'b0;
        repeat (n) step();
    endtask

    task automatic mdl_init();
        for (int r = 0; r < 8; r++) mdl[r] = 3'(r);
    endtask

    initial begin
        int n_upd;
        bus.Touch_En = 1'b0;
        bus.Coord_En = 1'b0;
        bus.X_Coord  = '0;
        bus.Y_Coord  = '0;
        bus.Clear    = 1'b0;
        bus.Coord_X  = '0;
        bus.Coord_Y  = '0;
        mdl_init();
        #2 Resetn = 1'b0;
        #1;
        chk("rst_rgb", {8'h0, bus.Red, bus.Green, bus.Blue}, 32'h0);
        chk("rst_region", 32'(bus.Region), 32'h0);
        chk("rst_update", 32'(bus.Update), 32'h0);
        chk("rst_count", 32'(bus.Touch_Count), 32'h0);
        step();
        step();
        Resetn = 1'b1;
        step();

        for (int x = 0; x < 800; x++) pix(x, 0, "sweep_x");
        pix(100, 300, "pix_r4");
        pix(700, 479, "pix_r7");
        pix(1000, 1000, "pix_clamp");
        pix(799, 239, "pix_r3_edge");

        touch(12'hC10, 12'h900);
        chk("t1_update", 32'(bus.Update), 32'h1);
        chk("t1_region", 32'(bus.Region), 32'h7);
        mdl[7] = mdl[7] + 3'd1;
        step();
        chk("t1_update_end", 32'(bus.Update), 32'h0);
        chk("t1_count", 32'(bus.Touch_Count), 32'h1);
        pix(700, 300, "t1_pix_black");

        n_upd = 0;
        for (int i = 0; i < 1000; i++) begin
            bus.Coord_En = (i % 100) == 0;
            step();
            if (bus.Update) n_upd++;
        end
        bus.Coord_En = 1'b0;
        chk("hold_updates", 32'(n_upd), 32'h0);
        chk("hold_count", 32'(bus.Touch_Count), 32'h1);

        release_for(RELI - 1);
        bus.Touch_En = 1'b1;
        step();
        step();
        touch(12'h800, 12'h000);
        chk("early_update", 32'(bus.Update), 32'h0);
        step();
        chk("early_count", 32'(bus.Touch_Count), 32'h1);

        release_for(RELI);
        touch(12'h800, 12'h000);
        chk("t2_update", 32'(bus.Update), 32'h1);
        chk("t2_region", 32'(bus.Region), 32'h2);
        mdl[2] = mdl[2] + 3'd1;
        step();
        chk("t2_count", 32'(bus.Touch_Count), 32'h2);
        pix(500, 0, "t2_pix");

        release_for(RELI);
        touch(12'h400, 12'h800);
        bus.Clear = 1'b1;
        chk("clr_update", 32'(bus.Update), 32'h1);
        chk("clr_region", 32'(bus.Region), 32'h5);
        step();
        bus.Clear = 1'b0;
        mdl_init();
        chk("clr_count", 32'(bus.Touch_Count), 32'h3);
        for (int r = 0; r < 8; r++) pix((r % 4) * 200 + 100, (r / 4) * 240 + 100, "clr_pix");

        Resetn = 1'b0;
        #1;
        chk("mid_rst_count", 32'(bus.Touch_Count), 32'h0);
        chk("mid_rst_region", 32'(bus.Region), 32'h0);
        chk("mid_rst_rgb", {8'h0, bus.Red, bus.Green, bus.Blue}, 32'h0);
        step();
        Resetn = 1'b1;
        touch(12'h400, 12'h000);
        chk("post_rst_update", 32'(bus.Update), 32'h1);
        chk("post_rst_region", 32'(bus.Region), 32'h1);
        mdl[1] = mdl[1] + 3'd1;
        step();
        chk("post_rst_count", 32'(bus.Touch_Count), 32'h1);
        pix(300, 0, "post_rst_pix");

        pix(198, 100, "line_x198");
        pix(199, 100, "line_x199");
        pix(200, 100, "line_x200");
        pix(100, 239, "line_y239");
        pix(100, 240, "line_y240");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
